// File: rtl/regfile_gen.sv
// Parametrised dual-port register file with byte enables, cross-port forwarding,
// collision merging, port-B pointer post-increment/pre-decrement and a post-reset clear sweep.
module regfile_gen #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned STEP   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  BUSY,
    input  logic                  A_EN,
    input  logic                  A_WEN,
    input  logic [DATA_W/8-1:0]   A_BYTE_EN,
    input  logic [ADDR_W-1:0]     A_ADDR,
    input  logic [DATA_W-1:0]     A_DIN,
    output logic [DATA_W-1:0]     A_DOUT,
    input  logic                  B_EN,
    input  logic                  B_WEN,
    input  logic [DATA_W/8-1:0]   B_BYTE_EN,
    input  logic [ADDR_W-1:0]     B_ADDR,
    input  logic [DATA_W-1:0]     B_DIN,
    output logic [DATA_W-1:0]     B_DOUT,
    input  logic [1:0]            B_PTR_OP,
    output logic                  COLLISION
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PTR_NONE = 2'b00,
        PTR_INC  = 2'b01,
        PTR_DEC  = 2'b10,
        PTR_RSVD = 2'b11
    } ptr_op_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   a_dout_q, a_dout_d;
    logic [DATA_W-1:0]   b_dout_q, b_dout_d;
    logic                collision_q, collision_d;

    logic [DATA_W-1:0]   a_old, b_old;
    logic [DATA_W-1:0]   a_new, b_new, both_new;
    logic                a_wr, b_wr, b_ptr, b_inc, same_addr, both_wr;
    ptr_op_e             ptr_op;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] din,
        input logic [LANES-1:0]  be
    );
        logic [DATA_W-1:0] r;
        r = base;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = din[i*8 +: 8];
            end
        end
        return r;
    endfunction

    // Per-port decode and candidate write values, all taken from start-of-cycle contents.
    always_comb begin
        ptr_op    = ptr_op_e'(B_PTR_OP);
        a_old     = mem_q[A_ADDR];
        b_old     = mem_q[B_ADDR];
        same_addr = (A_ADDR == B_ADDR);
        a_wr      = A_EN & A_WEN;
        b_inc     = B_EN & (ptr_op == PTR_INC);
        b_ptr     = B_EN & ((ptr_op == PTR_INC) | (ptr_op == PTR_DEC));
        b_wr      = B_EN & B_WEN & ~b_ptr;
        a_new     = merge_lanes(a_old, A_DIN, A_BYTE_EN);
        unique case (ptr_op)
            PTR_INC: b_new = b_old + DATA_W'(STEP);
            PTR_DEC: b_new = b_old - DATA_W'(STEP);
            default: b_new = merge_lanes(b_old, B_DIN, B_BYTE_EN);
        endcase
        both_wr   = a_wr & (b_wr | b_ptr) & same_addr;
        // On collision A's enabled lanes win; the rest come from B's result (which already holds old where B is idle).
        both_new  = merge_lanes(b_new, A_DIN, A_BYTE_EN);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_d       = mem_q;
        a_dout_d    = a_dout_q;
        b_dout_d    = b_dout_q;
        collision_d = 1'b0;

        unique case (state_q)
            CLEAR: begin
                a_dout_d = '0;
                b_dout_d = '0;
                if (!RESET) begin
                    mem_d[cnt_q] = '0;
                    cnt_d        = cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (!RESET) begin
                    if (both_wr) begin
                        mem_d[A_ADDR] = both_new;
                        collision_d   = 1'b1;
                    end else begin
                        if (b_wr | b_ptr) begin
                            mem_d[B_ADDR] = b_new;
                        end
                        if (a_wr) begin
                            mem_d[A_ADDR] = a_new;
                        end
                    end

                    if (A_EN) begin
                        if (a_wr) begin
                            a_dout_d = both_wr ? both_new : a_new;
                        end else if ((b_wr | b_ptr) & same_addr) begin
                            a_dout_d = b_new;
                        end else begin
                            a_dout_d = a_old;
                        end
                    end

                    if (B_EN) begin
                        if (b_inc) begin
                            b_dout_d = b_old;
                        end else if (b_wr | b_ptr) begin
                            b_dout_d = both_wr ? both_new : b_new;
                        end else if (a_wr & same_addr) begin
                            b_dout_d = a_new;
                        end else begin
                            b_dout_d = b_old;
                        end
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
        if (RESET) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
            collision_q <= collision_d;
        end
    end

    assign BUSY      = (state_q == CLEAR);
    assign A_DOUT    = a_dout_q;
    assign B_DOUT    = b_dout_q;
    assign COLLISION = collision_q;

endmodule

// File: tb/tb_regfile_gen.sv
// Bench for regfile_gen: directed scenarios then random traffic, checked against a
// word-level reference model of the register file kept in this file.
module tb_regfile_gen;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NREG  = 16;
    localparam logic [15:0] STEPV = 16'd2;

    logic        CLK = 1'b0;
    logic        RESET, BUSY;
    logic        A_EN, A_WEN, B_EN, B_WEN;
    logic [1:0]  A_BYTE_EN, B_BYTE_EN, B_PTR_OP;
    logic [3:0]  A_ADDR, B_ADDR;
    logic [15:0] A_DIN, B_DIN, A_DOUT, B_DOUT;
    logic        COLLISION;

    regfile_gen #(.DATA_W(DW), .ADDR_W(AW), .STEP(2)) dut (
        .CLK(CLK), .RESET(RESET), .BUSY(BUSY),
        .A_EN(A_EN), .A_WEN(A_WEN), .A_BYTE_EN(A_BYTE_EN), .A_ADDR(A_ADDR),
        .A_DIN(A_DIN), .A_DOUT(A_DOUT),
        .B_EN(B_EN), .B_WEN(B_WEN), .B_BYTE_EN(B_BYTE_EN), .B_ADDR(B_ADDR),
        .B_DIN(B_DIN), .B_DOUT(B_DOUT), .B_PTR_OP(B_PTR_OP),
        .COLLISION(COLLISION)
    );

    always #5 CLK = ~CLK;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model state
    logic [15:0] m_mem [NREG];
    logic        m_busy = 1'b1;
    int unsigned m_cnt  = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic        m_coll = 1'b0;

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a_en, input logic a_wen, input logic [1:0] a_be,
                         input logic [3:0] a_addr, input logic [15:0] a_din,
                         input logic b_en, input logic b_wen, input logic [1:0] b_be,
                         input logic [3:0] b_addr, input logic [15:0] b_din,
                         input logic [1:0] b_op);
        A_EN = a_en; A_WEN = a_wen; A_BYTE_EN = a_be; A_ADDR = a_addr; A_DIN = a_din;
        B_EN = b_en; B_WEN = b_wen; B_BYTE_EN = b_be; B_ADDR = b_addr; B_DIN = b_din;
        B_PTR_OP = b_op;
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT, compare.
    task automatic step();
        logic [15:0] old [NREG];
        logic [15:0] ma, a_val, b_val;
        logic a_wr, b_ptr, b_wr, hit, coll;
        if (RESET) begin
            m_busy = 1'b1; m_cnt = 0; m_a = '0; m_b = '0; m_coll = 1'b0;
        end else if (m_busy) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NREG) m_busy = 1'b0;
            m_a = '0; m_b = '0; m_coll = 1'b0;
        end else begin
            old   = m_mem;
            ma    = lane_mask(A_BYTE_EN);
            a_wr  = A_EN && A_WEN;
            b_ptr = B_EN && (B_PTR_OP == 2'b01 || B_PTR_OP == 2'b10);
            b_wr  = B_EN && B_WEN && !b_ptr;
            hit   = (A_ADDR == B_ADDR);
            a_val = (old[A_ADDR] & ~ma) | (A_DIN & ma);
            if (B_PTR_OP == 2'b01)      b_val = old[B_ADDR] + STEPV;
            else if (B_PTR_OP == 2'b10) b_val = old[B_ADDR] - STEPV;
            else b_val = (old[B_ADDR] & ~lane_mask(B_BYTE_EN)) | (B_DIN & lane_mask(B_BYTE_EN));
            coll = a_wr && (b_wr || b_ptr) && hit;
            if (coll) begin
                a_val = (b_val & ~ma) | (A_DIN & ma);
                b_val = a_val;
            end
            if (b_wr || b_ptr) m_mem[B_ADDR] = b_val;
            if (a_wr)          m_mem[A_ADDR] = a_val;
            if (A_EN)
                m_a = a_wr ? a_val : (((b_wr || b_ptr) && hit) ? b_val : old[A_ADDR]);
            if (B_EN) begin
                if (b_ptr && B_PTR_OP == 2'b01) m_b = old[B_ADDR];
                else if (b_wr || b_ptr)         m_b = b_val;
                else if (a_wr && hit)           m_b = a_val;
                else                            m_b = old[B_ADDR];
            end
            m_coll = coll;
        end
        @(posedge CLK);
        #1;
        chk("busy",      16'(BUSY),      16'(m_busy));
        chk("a_dout",    A_DOUT,         m_a);
        chk("b_dout",    B_DOUT,         m_b);
        chk("collision", 16'(COLLISION), 16'(m_coll));
    endtask

    initial begin
        for (int i = 0; i < int'(NREG); i++) m_mem[i] = 'x;
        idle();
        RESET = 1'b1;

        // Reset and sweep, with an ignored A write attempted while busy
        step();
        chk("reset_busy", 16'(BUSY), 16'h1);
        chk("reset_a",    A_DOUT,    16'h0000);
        RESET = 1'b0;
        drive(1, 1, 2'b11, 4'd4, 16'hFFFF, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 16; i++) step();
        chk("sweep_done", 16'(BUSY), 16'h0);
        drive(1, 0, 2'b00, 4'd4, 16'h0, 1, 0, 2'b00, 4'd9, 16'h0, 2'b00);
        step();
        chk("clear_r4", A_DOUT, 16'h0000);
        chk("clear_r9", B_DOUT, 16'h0000);

        // Byte-lane write
        drive(1, 1, 2'b11, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00); step();
        drive(1, 1, 2'b01, 4'd3, 16'hAB55, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00); step();
        chk("bytewr_dout", A_DOUT, 16'h1255);
        drive(1, 0, 2'b00, 4'd3, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00); step();
        chk("bytewr_read", A_DOUT, 16'h1255);

        // Cross-port forwarding
        drive(1, 1, 2'b11, 4'd5, 16'hBEEF, 1, 0, 2'b00, 4'd5, 16'h0, 2'b00); step();
        chk("fwd_b", B_DOUT, 16'hBEEF);
        chk("fwd_coll", 16'(COLLISION), 16'h0);

        // Pointer ops on R13 with wrap
        idle(); B_EN = 1; B_ADDR = 4'd13; B_PTR_OP = 2'b10; B_WEN = 1; B_BYTE_EN = 2'b00; step();
        chk("predec", B_DOUT, 16'hFFFE);
        B_PTR_OP = 2'b01; step();
        chk("postinc", B_DOUT, 16'hFFFE);
        B_PTR_OP = 2'b00; B_WEN = 0; step();
        chk("ptr_wrap", B_DOUT, 16'h0000);

        // Write collision on R2
        drive(1, 1, 2'b10, 4'd2, 16'h1100, 1, 1, 2'b11, 4'd2, 16'h0022, 2'b00); step();
        chk("coll_a", A_DOUT, 16'h1122);
        chk("coll_b", B_DOUT, 16'h1122);
        chk("coll_pulse", 16'(COLLISION), 16'h1);
        drive(1, 0, 2'b00, 4'd2, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00); step();
        chk("coll_end", 16'(COLLISION), 16'h0);
        chk("coll_r2", A_DOUT, 16'h1122);

        // Random traffic; a narrow address range keeps collisions and forwarding frequent
        for (int n = 0; n < 600; n++) begin
            int unsigned span;
            span = ($urandom_range(0, 1) != 0) ? 3 : 15;
            A_EN      = ($urandom_range(0, 3) != 0);
            A_WEN     = 1'($urandom_range(0, 1));
            A_BYTE_EN = 2'($urandom_range(0, 3));
            A_ADDR    = 4'($urandom_range(0, span));
            A_DIN     = 16'($urandom);
            B_EN      = ($urandom_range(0, 3) != 0);
            B_WEN     = 1'($urandom_range(0, 1));
            B_BYTE_EN = 2'($urandom_range(0, 3));
            B_ADDR    = 4'($urandom_range(0, span));
            B_DIN     = 16'($urandom);
            B_PTR_OP  = 2'($urandom_range(0, 3));
            step();
        end

        // Reset reasserted part-way through the sweep
        idle(); RESET = 1'b1; step();
        RESET = 1'b0;
        for (int i = 0; i < 7; i++) step();
        RESET = 1'b1; step();
        RESET = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("restart_busy15", 16'(BUSY), 16'h1);
        step();
        chk("restart_busy16", 16'(BUSY), 16'h0);
        for (int r = 0; r < int'(NREG); r++) begin
            drive(1, 0, 2'b00, 4'(r), 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_gen.md
# regfile_gen

Parametrised dual-port register file that generalises the CPU's fixed 16×16 register bank. Data width and register count are configurable, and both ports can write with byte enables. It adds four behaviours the current bank lacks: same-cycle cross-port forwarding, a defined write-collision priority with a flag, an atomic pointer post-increment/pre-decrement on port B for stack and frame pointers, and a hardware clear sweep after reset. It sits between the decode/ALU datapath and the address/data muxes, replacing the vendor EBR wrapper.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W registers.
- STEP, 2, pointer increment/decrement amount; must be less than 2^DATA_W.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high; starts the clear sweep.
- BUSY  out  1  high while the clear sweep runs; all accesses are ignored while high.
- A_EN  in  1  port A access enable.
- A_WEN  in  1  port A write; qualified by A_EN.
- A_BYTE_EN  in  DATA_W/8  port A byte-lane write enables.
- A_ADDR  in  ADDR_W  port A register address.
- A_DIN  in  DATA_W  port A write data.
- A_DOUT  out  DATA_W  port A registered read data.
- B_EN, B_WEN, B_BYTE_EN, B_ADDR, B_DIN, B_DOUT  same widths and meanings as port A, for port B.
- B_PTR_OP  in  2  port B pointer operation: 00 none, 01 post-increment, 10 pre-decrement, 11 treated as 00.
- COLLISION  out  1  one-cycle pulse: both ports wrote the same address in the previous cycle.

## Operation
- States: CLEAR and READY. RESET forces CLEAR and sets the sweep counter to 0.
- CLEAR: each cycle with RESET low, write 0 to entry[cnt], then cnt++. On the edge that writes entry DEPTH-1, go to READY. RESET reasserted mid-sweep restarts at entry 0.
- While in CLEAR, EN/WEN/PTR_OP on both ports are ignored, DOUTs hold 0 and COLLISION stays 0.
- Read (EN=1, WEN=0, PTR_OP=00): DOUT <= entry[ADDR] on the next edge.
- Write (EN=1, WEN=1): byte lanes with BYTE_EN set are replaced from DIN; other lanes are kept. The port's DOUT <= merged new value (write-first).
- Pointer op (B_EN=1, B_PTR_OP≠00): B_WEN and B_BYTE_EN are ignored and the full word is updated.
  - Post-increment: entry <= old+STEP, B_DOUT <= old.
  - Pre-decrement: entry <= old−STEP, B_DOUT <= new.
  - Arithmetic is modulo 2^DATA_W; wrap is silent.
- "old" is always the array content at the start of the cycle.
- Forwarding: a plain read on one port of an address the other port writes in the same cycle returns the merged new value, including the pointer-op result.
- Same-address write on both ports (A write with B write or B pointer op):
  - Lanes with A_BYTE_EN set take A_DIN.
  - Remaining lanes take B's value (B_DIN lanes under B_BYTE_EN, or the pointer result).
  - Lanes enabled by neither port keep old.
  - Both DOUTs show the final merged word.
  - COLLISION=1 on the next cycle.
- Post-increment B_DOUT is unaffected by a collision and still returns old.
- EN=0 on a port: that port's DOUT holds its previous value.

## Timing
- Reset values: BUSY=1, A_DOUT=0, B_DOUT=0, COLLISION=0, state=CLEAR, cnt=0.
- Clear sweep: with RESET high in cycle 0 and low from cycle 1, entries 0..DEPTH−1 are written in cycles 1..DEPTH. BUSY reads 0 from cycle DEPTH+1, which is the first cycle an access is accepted.
- Read latency is 1 cycle for both ports, including forwarded and pointer results. There is no stall and no backpressure.
- Back-to-back pointer ops on the same address in consecutive cycles see each other's results; there is no hazard.

## Test plan
- Reset sweep, DEPTH=16: pulse RESET for 1 cycle -> BUSY high for 16 cycles after release; a read of any register afterwards returns 0x0000; an A write during BUSY has no effect.
- Byte write: A writes 0x1234 to R3 with BYTE_EN=11, then writes 0xAB55 with BYTE_EN=01 -> A read of R3 returns 0x1255.
- Forwarding: A writes 0xBEEF to R5 while B reads R5 in the same cycle -> B_DOUT=0xBEEF next cycle, COLLISION=0.
- Pointer ops on R13=0x0000, STEP=2:
  - Pre-decrement -> B_DOUT=0xFFFE, R13=0xFFFE.
  - Then post-increment -> B_DOUT=0xFFFE, R13=0x0000 (wrap).
- Collision: R2=0x0000; A writes 0x1100 with BYTE_EN=10 and B writes 0x0022 with BYTE_EN=11 to R2 -> R2=0x1122, both DOUTs 0x1122, COLLISION pulses for exactly 1 cycle.
- Reset mid-sweep: assert RESET at sweep cycle 7 for 1 cycle -> sweep restarts at entry 0 and BUSY stays high a further 16 cycles.
